// File: rtl/threshold_simd_pkg.sv
// Shared types and pixel constants for the SIMD threshold scheduler.
package threshold_simd_pkg;

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} sched_state_e;

  typedef logic [7:0] pixel_t;

  localparam pixel_t PIX_ON  = 8'hFF;
  localparam pixel_t PIX_OFF = 8'h00;

endpackage

// File: rtl/threshold_simd_lanes.sv
// Combinational SIMD binariser: each 8-bit lane becomes PIX_ON when strictly above
// the threshold (unsigned), else PIX_OFF.
module threshold_simd_lanes
  import threshold_simd_pkg::*;
#(
  parameter int SIMD_WIDTH = 4
) (
  input  logic [8*SIMD_WIDTH-1:0] word,
  input  pixel_t                  threshold,
  output logic [8*SIMD_WIDTH-1:0] bin_word
);

  for (genvar k = 0; k < SIMD_WIDTH; k++) begin : g_lane
    assign bin_word[8*k +: 8] = (pixel_t'(word[8*k +: 8]) > threshold) ? PIX_ON : PIX_OFF;
  end

endmodule

// File: rtl/threshold_simd_sched.sv
// Word-by-word read/threshold/write sequencer over a shared memory port (3 cycles/word floor).
// Optional cycle counter enabled by defining THRESH_SCHED_PERF_CNT_EN.
module threshold_simd_sched
  import threshold_simd_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 64,
  parameter int SIMD_WIDTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [7:0]              threshold_i,
  input  logic [ADDR_W-1:0]       src_base_i,
  input  logic [ADDR_W-1:0]       dst_base_i,
  output logic                    rd_req_o,
  output logic [ADDR_W-1:0]       rd_addr_o,
  input  logic                    rd_gnt_i,
  input  logic                    rd_valid_i,
  input  logic [8*SIMD_WIDTH-1:0] rd_data_i,
  output logic                    wr_req_o,
  output logic [ADDR_W-1:0]       wr_addr_o,
  output logic [8*SIMD_WIDTH-1:0] wr_data_o,
  input  logic                    wr_gnt_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [31:0]             cycle_cnt_o
);

  localparam int WORDS = HEIGHT * WIDTH / SIMD_WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  if (WIDTH % SIMD_WIDTH != 0) begin : g_width_chk
    $fatal(1, "threshold_simd_sched: WIDTH must be a multiple of SIMD_WIDTH");
  end

  sched_state_e            state_q, state_d;
  logic [IDX_W-1:0]        idx_q;
  pixel_t                  thr_q;
  logic [ADDR_W-1:0]       src_q, dst_q;
  logic [8*SIMD_WIDTH-1:0] wr_data_q, lane_word;
  logic                    start_acc, last_word;

  assign start_acc = (state_q == IDLE) && start_i;
  assign last_word = (idx_q == IDX_W'(WORDS - 1));

  threshold_simd_lanes #(.SIMD_WIDTH(SIMD_WIDTH)) u_lanes (
    .word      (rd_data_i),
    .threshold (thr_q),
    .bin_word  (lane_word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i)    state_d = RD;
      RD:      if (rd_gnt_i)   state_d = WAIT;
      WAIT:    if (rd_valid_i) state_d = WR;
      WR:      if (wr_gnt_i)   state_d = last_word ? DONE : RD;
      DONE:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      thr_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        thr_q <= threshold_i;
        src_q <= src_base_i;
        dst_q <= dst_base_i;
        idx_q <= '0;
      end
      // Result is captured with the read data so WR starts with a stable word.
      if (state_q == WAIT && rd_valid_i) wr_data_q <= lane_word;
      if (state_q == WR && wr_gnt_i && !last_word) idx_q <= idx_q + 1'b1;
    end
  end

  assign rd_req_o  = (state_q == RD);
  assign wr_req_o  = (state_q == WR);
  assign busy_o    = (state_q == RD) || (state_q == WAIT) || (state_q == WR);
  assign done_o    = (state_q == DONE);
  assign rd_addr_o = src_q + ADDR_W'(idx_q);
  assign wr_addr_o = dst_q + ADDR_W'(idx_q);
  assign wr_data_o = wr_data_q;

`ifdef THRESH_SCHED_PERF_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          cnt_q <= '0;
    else if (start_acc)                   cnt_q <= '0;
    else if (busy_o && cnt_q != '1)       cnt_q <= cnt_q + 32'd1;
  end

  assign cycle_cnt_o = cnt_q;
`else
  assign cycle_cnt_o = '0;
`endif

endmodule

// File: tb/tb_threshold_simd_sched.sv
// Directed bench for threshold_simd_sched: reset, lane rule, handshake holds, abort, full image.
module tb_threshold_simd_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [7:0]  threshold_i;
  logic [31:0] src_base_i, dst_base_i;
  logic        rd_req_o, rd_gnt_i, rd_valid_i;
  logic [31:0] rd_addr_o, rd_data_i;
  logic        wr_req_o, wr_gnt_i;
  logic [31:0] wr_addr_o, wr_data_o;
  logic        busy_o, done_o;
  logic [31:0] cycle_cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  threshold_simd_sched dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .threshold_i (threshold_i),
    .src_base_i  (src_base_i),
    .dst_base_i  (dst_base_i),
    .rd_req_o    (rd_req_o),
    .rd_addr_o   (rd_addr_o),
    .rd_gnt_i    (rd_gnt_i),
    .rd_valid_i  (rd_valid_i),
    .rd_data_i   (rd_data_i),
    .wr_req_o    (wr_req_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .wr_gnt_i    (wr_gnt_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .cycle_cnt_o (cycle_cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b * 8'd5, b ^ 8'h5A, a[15:8] + b};
  endfunction

  function automatic logic [31:0] binarise(input logic [31:0] w, input logic [7:0] t);
    logic [31:0] r;
    logic [7:0]  p;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      p = w[8*k +: 8];
      r[8*k +: 8] = (p > t) ? 8'hFF : 8'h00;
    end
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_req"},  rd_req_o,  1'b0);
    check({tag, "_wr_req"},  wr_req_o,  1'b0);
    check({tag, "_rd_addr"}, rd_addr_o, 32'h0);
    check({tag, "_wr_addr"}, wr_addr_o, 32'h0);
    check({tag, "_wr_data"}, wr_data_o, 32'h0);
    check({tag, "_busy"},    busy_o,    1'b0);
    check({tag, "_done"},    done_o,    1'b0);
    check({tag, "_cnt"},     cycle_cnt_o, 32'h0);
  endtask

  initial begin
    logic        found;
    int          writes, dones, cyc, after_done;
    logic [31:0] exp_cnt;

    rst_ni = 1'b0; start_i = 1'b0; threshold_i = '0;
    src_base_i = '0; dst_base_i = '0;
    rd_gnt_i = 1'b0; rd_valid_i = 1'b0; rd_data_i = '0; wr_gnt_i = 1'b0;
    repeat (2) step();
    check_all_zero("reset");
    rst_ni = 1'b1;
    step();

    // Lane rule, read/write holds, ignored start and spurious valid
    threshold_i = 8'd128; src_base_i = 32'h200; dst_base_i = 32'h300; start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("rd_req_first", rd_req_o, 1'b1);
    check("rd_addr_first", rd_addr_o, 32'h200);
    check("busy_first", busy_o, 1'b1);
    rd_gnt_i = 1'b0; rd_valid_i = 1'b1; rd_data_i = 32'hDEADBEEF; threshold_i = 8'd0;
    for (int i = 0; i < 5; i++) begin
      start_i = (i == 2);
      step();
      check("rdhold_req", rd_req_o, 1'b1);
      check("rdhold_addr", rd_addr_o, 32'h200);
      check("rdhold_wr_req", wr_req_o, 1'b0);
    end
    start_i = 1'b0; rd_valid_i = 1'b0; rd_gnt_i = 1'b1;
    step();
    rd_gnt_i = 1'b0;
    check("wait_rd_req", rd_req_o, 1'b0);
    check("wait_busy", busy_o, 1'b1);
    rd_valid_i = 1'b1; rd_data_i = 32'h808100FF;
    step();
    rd_valid_i = 1'b0;
    check("lane_wr_req", wr_req_o, 1'b1);
    check("lane_wr_addr", wr_addr_o, 32'h300);
    check("lane_wr_data", wr_data_o, 32'h00FF00FF);
    for (int i = 0; i < 3; i++) begin
      step();
      check("wrhold_req", wr_req_o, 1'b1);
      check("wrhold_addr", wr_addr_o, 32'h300);
      check("wrhold_data", wr_data_o, 32'h00FF00FF);
    end
    wr_gnt_i = 1'b1;
    step();
    wr_gnt_i = 1'b0;
    check("next_rd_req", rd_req_o, 1'b1);
    check("next_rd_addr", rd_addr_o, 32'h201);

    // Run on to word 10 in WR, then abort with reset
    rd_gnt_i = 1'b1; wr_gnt_i = 1'b1; rd_valid_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (wr_req_o && wr_addr_o == 32'h30A) found = 1'b1;
      else step();
    end
    check("reach_idx10", found, 1'b1);
    rst_ni = 1'b0;
    rd_gnt_i = 1'b0; wr_gnt_i = 1'b0; rd_valid_i = 1'b0;
    #1;
    check_all_zero("abort");
    step();
    check_all_zero("abort_next");
    rst_ni = 1'b1;
    step();
    check("idle_after_abort", busy_o, 1'b0);

    // Full image with single-cycle grant and valid
    threshold_i = 8'd100; src_base_i = 32'h40; dst_base_i = 32'h1000; start_i = 1'b1;
    step();
    start_i = 1'b0; threshold_i = 8'd7;
    check("full_rd_addr0", rd_addr_o, 32'h40);
    rd_gnt_i = 1'b1; wr_gnt_i = 1'b1; rd_valid_i = 1'b1;
`ifdef THRESH_SCHED_PERF_CNT_EN
    exp_cnt = 32'd3072;
`else
    exp_cnt = 32'd0;
`endif
    writes = 0; dones = 0; after_done = -1;
    for (cyc = 0; cyc < 5000 && after_done < 4; cyc++) begin
      start_i = 1'b0;
      if (after_done >= 0) after_done++;
      if (after_done == 1) check("done_start_ignored", busy_o, 1'b0);
      rd_data_i = pat(rd_addr_o);
      if (wr_req_o) begin
        check("full_wr_addr", wr_addr_o, 32'h1000 + writes);
        check("full_wr_data", wr_data_o, binarise(pat(32'h40 + writes), 8'd100));
        writes++;
      end
      if (done_o) begin
        dones++;
        check("done_busy_low", busy_o, 1'b0);
        check("done_cycle_cnt", cycle_cnt_o, exp_cnt);
        if (after_done < 0) begin
          after_done = 0;
          start_i = 1'b1;
        end
      end
      step();
    end
    start_i = 1'b0;
    check("full_no_timeout", (after_done >= 0), 1'b1);
    check("full_writes", writes, 1024);
    check("full_done_pulses", dones, 1);
    check("cnt_hold", cycle_cnt_o, exp_cnt);
    check("final_idle", busy_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
